// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types, segment constants and BCD sizing for the multiplexed seven-segment display.
package ssd_pkg;
  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
  // What a display position shows: a decoded digit, or one of the fixed glyphs.
  typedef enum logic [1:0] {G_DIG, G_BLANK, G_MINUS, G_E} glyph_t;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  // BCD digits needed for a w-bit magnitude, plus one spare.
  function automatic int nbcd(input int w);
    return (3 * w + 9) / 10 + 1;
  endfunction
endpackage

// File: rtl/ssd_seg_decode.sv
// ssd_seg_decode: 4-bit digit to active-low {g,f,e,d,c,b,a} pattern, hex glyphs A-F included.
//   digit : input digit 0..15
//   seg   : active-low segment pattern
module ssd_seg_decode (
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  localparam logic [6:0] LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  assign seg = LUT[digit];
endmodule

// File: rtl/ssd_mux_display.sv
// ssd_mux_display: scanned seven-segment display of a hex or signed-decimal value.
//   clk_500  : scan and conversion clock
//   rst      : asynchronous active-high reset
//   in_valid/in_ready/in_value/in_dec : value handshake; in_dec=1 decimal, 0 hex
//   an       : active-low one-hot anode select
//   ca       : active-low cathodes {g,f,e,d,c,b,a}
//   overflow : last decimal value did not fit
// Optional: define SSD_BLANK_LZ_EN to blank leading zeros in decimal mode.
module ssd_mux_display
  import ssd_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 32
) (
  input  logic               clk_500,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VALUE_W-1:0] in_value,
  input  logic               in_dec,
  output logic [DIGITS-1:0]  an,
  output logic [6:0]         ca,
  output logic               overflow
);
  localparam int NBCD = nbcd(VALUE_W);
  // BCD register is at least DIGITS wide so every display position has a source digit.
  localparam int NB = NBCD > DIGITS ? NBCD : DIGITS;
  localparam int HW = VALUE_W > 4 * DIGITS ? VALUE_W : 4 * DIGITS;
  localparam int CW = $clog2(VALUE_W);
  localparam int PW = $clog2(DIGITS);

  state_t            state, state_n;
  logic [VALUE_W:0]  mag;
  logic [4*NB-1:0]   bcd, bcd_adj;
  logic [CW-1:0]     cnt;
  logic              neg;
  logic [PW-1:0]     pos;
  glyph_t            kind [DIGITS];
  glyph_t            kind_n [DIGITS];
  logic [3:0]        val [DIGITS];
  logic [3:0]        val_n [DIGITS];
  logic              overflow_n;
  logic [6:0]        seg;
  logic [HW-1:0]     hex_src;
  logic              accept;
  int                avail;
  logic              unused_ok;
`ifdef SSD_BLANK_LZ_EN
  int                msd;
`endif

  assign accept    = in_valid && in_ready;
  assign hex_src   = HW'(in_value);
  assign avail     = neg ? DIGITS - 1 : DIGITS;
  // The top adjusted BCD bit shifts out and mag's extra bit only holds the sign-safe width.
  assign unused_ok = &{1'b0, bcd_adj[4*NB-1], mag[VALUE_W], hex_src};

  always_ff @(posedge clk_500 or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;

  always_comb begin
    in_ready = state == IDLE;
    state_n  = state == IDLE ? (accept && in_dec ? CONV : IDLE)
             : state == CONV ? (cnt == CW'(VALUE_W - 1) ? DONE : CONV)
             : IDLE;
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NB; i++)
      bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end

  // Magnitude is negated at VALUE_W+1 bits so the most negative input converts correctly.
  always_ff @(posedge clk_500 or posedge rst)
    if (rst) begin
      mag <= '0;
      bcd <= '0;
      cnt <= '0;
      neg <= 1'b0;
    end else if (state == IDLE && accept && in_dec) begin
      neg <= in_value[VALUE_W-1];
      mag <= in_value[VALUE_W-1] ? -{in_value[VALUE_W-1], in_value} : {1'b0, in_value};
      bcd <= '0;
      cnt <= '0;
    end else if (state == CONV) begin
      bcd <= {bcd_adj[4*NB-2:0], mag[VALUE_W-1]};
      mag <= mag << 1;
      cnt <= cnt + 1'b1;
    end

  always_comb begin
    overflow_n = 1'b0;
`ifdef SSD_BLANK_LZ_EN
    msd = 0;
`endif
    for (int i = 0; i < NB; i++) begin
      overflow_n = overflow_n | (i >= avail && bcd[4*i+:4] != 4'd0);
`ifdef SSD_BLANK_LZ_EN
      msd = (i < avail && bcd[4*i+:4] != 4'd0) ? i : msd;
`endif
    end
    for (int i = 0; i < DIGITS; i++) begin
      val_n[i] = bcd[4*i+:4];
`ifdef SSD_BLANK_LZ_EN
      kind_n[i] = overflow_n ? G_E : (neg && i == msd + 1) ? G_MINUS : (i > msd) ? G_BLANK : G_DIG;
`else
      kind_n[i] = overflow_n ? G_E : (neg && i == DIGITS - 1) ? G_MINUS : G_DIG;
`endif
    end
  end

  always_ff @(posedge clk_500 or posedge rst)
    if (rst) begin
      overflow <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        kind[i] <= G_DIG;
        val[i]  <= 4'd0;
      end
    end else if (state == IDLE && accept && !in_dec) begin
      overflow <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        kind[i] <= G_DIG;
        val[i]  <= hex_src[4*i+:4];
      end
    end else if (state == DONE) begin
      overflow <= overflow_n;
      for (int i = 0; i < DIGITS; i++) begin
        kind[i] <= kind_n[i];
        val[i]  <= val_n[i];
      end
    end

  always_ff @(posedge clk_500 or posedge rst)
    if (rst) pos <= '0;
    else pos <= pos == PW'(DIGITS - 1) ? '0 : pos + 1'b1;

  assign an = ~(DIGITS'(1) << pos);

  ssd_seg_decode u_dec (
    .digit(val[pos]),
    .seg  (seg)
  );

  assign ca = kind[pos] == G_DIG   ? seg
            : kind[pos] == G_BLANK ? SEG_BLANK
            : kind[pos] == G_MINUS ? SEG_MINUS
            : SEG_E;
endmodule

// File: tb/tb_ssd_mux_display.sv
// tb_ssd_mux_display: directed test of ssd_mux_display against an arithmetic display model.
module tb_ssd_mux_display;
  logic        clk_500 = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = '0;
  logic        in_dec = 1'b0;
  logic [3:0]  an;
  logic [6:0]  ca;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  ssd_mux_display #(.DIGITS(4), .VALUE_W(32)) dut (
    .clk_500 (clk_500),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_value(in_value),
    .in_dec  (in_dec),
    .an      (an),
    .ca      (ca),
    .overflow(overflow)
  );

  always #5 clk_500 = ~clk_500;

  localparam logic [6:0] S_MIN = 7'b0111111;
  localparam logic [6:0] S_BLK = 7'b1111111;
  localparam logic [6:0] S_E   = 7'b0000110;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic longint mag_of(input logic [31:0] v);
    return v[31] ? -longint'($signed(v)) : longint'(v);
  endfunction

  function automatic bit model_ovf(input logic [31:0] v, input bit dec);
    longint lim = 1;
    if (!dec) return 1'b0;
    repeat (v[31] ? 3 : 4) lim = lim * 10;
    return mag_of(v) >= lim;
  endfunction

  // Expected glyphs for digits 3..0, packed {d3,d2,d1,d0}.
  function automatic logic [27:0] model_disp(input logic [31:0] v, input bit dec);
    logic [27:0] r;
    longint m, p, t;
    int nd;
    bit neg;
    r = '0;
    if (!dec) begin
      for (int i = 0; i < 4; i++) r[7*i+:7] = seg_of(int'(v[4*i+:4]));
      return r;
    end
    if (model_ovf(v, dec)) return {4{S_E}};
    neg = v[31];
    m = mag_of(v);
    nd = 1;
    t = m / 10;
    while (t > 0) begin nd++; t = t / 10; end
    p = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef SSD_BLANK_LZ_EN
      r[7*i+:7] = i < nd ? seg_of(int'((m / p) % 10)) : (neg && i == nd) ? S_MIN : S_BLK;
`else
      r[7*i+:7] = (neg && i == 3) ? S_MIN : seg_of(int'((m / p) % 10));
`endif
      p = p * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] an_of(input int p);
    return ~(4'b0001 << p);
  endfunction

  // Model state: scan position, shown glyphs, pending decimal result and busy countdown.
  int          m_pos, m_busy;
  logic [27:0] m_disp, m_pend;
  bit          m_ovf, m_pend_ovf;

  always @(posedge clk_500 or posedge rst)
    if (rst) begin
      m_pos  <= 0;
      m_disp <= {4{7'h40}};
      m_ovf  <= 1'b0;
      m_busy <= 0;
    end else begin
      m_pos <= (m_pos + 1) % 4;
      if (m_busy > 0) begin
        m_busy <= m_busy - 1;
        if (m_busy == 1) begin
          m_disp <= m_pend;
          m_ovf  <= m_pend_ovf;
        end
      end else if (in_valid) begin
        if (in_dec) begin
          m_pend     <= model_disp(in_value, 1'b1);
          m_pend_ovf <= model_ovf(in_value, 1'b1);
          m_busy     <= 33;
        end else begin
          m_disp <= model_disp(in_value, 1'b0);
          m_ovf  <= 1'b0;
        end
      end
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_500)
    if (chk_en) begin
      chk("an", 32'(an), 32'(an_of(m_pos)));
      chk("ca", 32'(ca), 32'(m_disp[7*m_pos+:7]));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("in_ready", 32'(in_ready), 32'(m_busy == 0));
    end

  task automatic tick();
    @(posedge clk_500);
    #2;
  endtask

  task automatic send(input logic [31:0] v, input bit d);
    in_value = v;
    in_dec   = d;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic check_digits(input string nm, input logic [6:0] d3, d2, d1, d0);
    logic [27:0] e;
    e = {d3, d2, d1, d0};
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      while (an !== an_of(k) && n < 8) begin tick(); n++; end
      chk({nm, "_an"}, 32'(an), 32'(an_of(k)));
      chk({nm, "_ca"}, 32'(ca), 32'(e[7*k+:7]));
    end
  endtask

  initial begin
    int n;
    chk("pin_1234", 32'(model_disp(32'd1234, 1'b1)), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
    chk("pin_ovf_10000", 32'(model_ovf(32'd10000, 1'b1)), 32'd1);
    chk("pin_ovf_m999", 32'(model_ovf(-32'sd999, 1'b1)), 32'd0);
    tick();
    chk_en = 1;
    repeat (2) tick();
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_ca", 32'(ca), 32'h40);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0;
    chk("scan0", 32'(an), 32'hE);
    tick(); chk("scan1", 32'(an), 32'hD); chk("scan1_ca", 32'(ca), 32'h40);
    tick(); chk("scan2", 32'(an), 32'hB); chk("scan2_ca", 32'(ca), 32'h40);
    tick(); chk("scan3", 32'(an), 32'h7); chk("scan3_ca", 32'(ca), 32'h40);
    tick(); chk("scan4", 32'(an), 32'hE);

    send(32'h0000BEEF, 1'b0);
    chk("hex_ready", 32'(in_ready), 32'd1);
    check_digits("hex_beef", 7'h03, S_E, S_E, 7'h0E);
    chk("hex_ovf", 32'(overflow), 32'd0);

    send(32'd1234, 1'b1);
    n = 0;
    while (!in_ready && n < 100) begin
      in_valid = n < 5;
      in_value = 32'd99;
      in_dec   = 1'b0;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chk("dec_latency", 32'(n), 32'd33);
    check_digits("dec_1234", 7'h79, 7'h24, 7'h30, 7'h19);
    chk("dec_1234_ovf", 32'(overflow), 32'd0);

    send(-32'sd42, 1'b1); wait_ready();
`ifdef SSD_BLANK_LZ_EN
    check_digits("dec_m42", S_BLK, S_MIN, 7'h19, 7'h24);
`else
    check_digits("dec_m42", S_MIN, 7'h40, 7'h19, 7'h24);
`endif
    chk("dec_m42_ovf", 32'(overflow), 32'd0);

    send(32'd10000, 1'b1); wait_ready();
    chk("ovf_10000", 32'(overflow), 32'd1);
    check_digits("ovf_10000", S_E, S_E, S_E, S_E);

    send(-32'sd1000, 1'b1); wait_ready();
    chk("ovf_m1000", 32'(overflow), 32'd1);

    send(-32'sd999, 1'b1); wait_ready();
    chk("ovf_m999", 32'(overflow), 32'd0);
    check_digits("dec_m999", S_MIN, 7'h10, 7'h10, 7'h10);

    send(32'h80000000, 1'b1); wait_ready();
    chk("ovf_min", 32'(overflow), 32'd1);

    send(32'd5555, 1'b1);
    repeat (10) tick();
    rst = 1'b1;
    #1;
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_ovf", 32'(overflow), 32'd0);
    tick();
    rst = 1'b0;
    check_digits("abort_zero", 7'h40, 7'h40, 7'h40, 7'h40);

    send(32'd7, 1'b1); wait_ready();
`ifdef SSD_BLANK_LZ_EN
    check_digits("dec_7", S_BLK, S_BLK, S_BLK, 7'h78);
`else
    check_digits("dec_7", 7'h40, 7'h40, 7'h40, 7'h78);
`endif
    repeat (4) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ssd_mux_display.md
SSD_MUX_DISPLAY -- requirements
Module: ssd_mux_display

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed seven-segment digits (2..8).
REQ-002 Parameter VALUE_W, default 32: input value width (8..32).
REQ-003 Port clk_500, input, 1 bit: scan and conversion clock.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 Port in_valid, input, 1 bit: a new value is offered.
REQ-006 Port in_ready, output, 1 bit: block accepts a value this cycle.
REQ-007 Port in_value, input, VALUE_W bits: value to display.
REQ-008 Port in_dec, input, 1 bit: 1 selects signed decimal, 0 selects hex; sampled together with in_value.
REQ-009 Port an, output, DIGITS bits: active-low one-hot anode select.
REQ-010 Port ca, output, 7 bits: active-low cathodes, ordered {g,f,e,d,c,b,a}.
REQ-011 Port overflow, output, 1 bit: the last accepted decimal value does not fit in DIGITS positions.

Function
REQ-012 The block SHALL accept a value on a clk_500 edge where in_valid and in_ready are both 1.
REQ-013 States SHALL be IDLE, CONV and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 For a hex accept, the block SHALL stay in IDLE and SHALL load digit i with in_value[4i+3:4i] on the accepting edge; overflow SHALL go to 0 on that edge.
REQ-015 For a decimal accept, the block SHALL enter CONV and SHALL load the magnitude: two's-complement negated if in_value[VALUE_W-1]=1, held VALUE_W+1 bits wide so that -2^(VALUE_W-1) is converted correctly.
REQ-016 CONV SHALL run a shift-add-3 (double-dabble) conversion for exactly VALUE_W cycles into NBCD = (3*VALUE_W+9)/10+1 BCD digits.
REQ-017 The next state after CONV SHALL be DONE; DONE SHALL update the display and overflow and SHALL return to IDLE.
REQ-018 The display SHALL update on the (VALUE_W+1)th edge after the accepting edge; for VALUE_W=32 this is 33 edges.
REQ-019 The display SHALL hold the previous value throughout CONV.
REQ-020 in_valid SHALL be ignored while in_ready is 0.
REQ-021 A negative decimal value SHALL show a minus sign (ca=0111111) and SHALL have only DIGITS-1 positions available for its magnitude; a non-negative value has DIGITS positions.
REQ-022 Overflow: if any BCD digit above the available positions is nonzero, overflow SHALL be 1 and every digit SHALL show 'E' (0000110).
REQ-023 Scan: exactly one bit of an SHALL be low; the low bit SHALL move from digit i to digit i+1 each edge and wrap from DIGITS-1 to 0.
REQ-024 ca SHALL be the pattern for the digit whose anode is low in the same cycle, with no extra cycle of latency.

Reset
REQ-025 While rst=1, the block SHALL be in IDLE, in_ready SHALL be 1, overflow SHALL be 0, and an SHALL have only bit 0 low.
REQ-026 While rst=1, all display digits SHALL be 0, so ca=1000000 without SSD_BLANK_LZ_EN.
REQ-027 Reset during CONV or DONE SHALL abort the conversion without any display update.

Configuration
REQ-028 Macro SSD_BLANK_LZ_EN, when defined, SHALL blank zero digits above the most significant nonzero digit (ca=1111111); digit 0 SHALL always be shown.
REQ-029 With SSD_BLANK_LZ_EN defined, the minus sign SHALL occupy the position directly left of the most significant shown digit.
REQ-030 Without SSD_BLANK_LZ_EN, all digits SHALL be shown, including leading zeros, and the minus sign SHALL occupy digit DIGITS-1.
REQ-031 Hex mode and overflow behaviour SHALL be identical with and without the macro.

Structure
REQ-032 Package ssd_pkg SHALL hold the state enum, the constants SEG_BLANK, SEG_MINUS and SEG_E, and the NBCD computation function.
REQ-033 Sub-module ssd_seg_decode SHALL map a 4-bit digit to a 7-bit active-low pattern, including A-F, and shall be instanced once on the scan-selected digit.

Verification (DIGITS=4, VALUE_W=32)
REQ-034 Reset release: an SHALL sequence 1110, 1101, 1011, 0111, 1110; ca=1000000 on every digit without the macro.
REQ-035 Hex 32'h0000BEEF, in_dec=0: on the next scan pass, digits 0..3 SHALL show F, E, E, B, i.e. ca=0001110 when an=1110; in_ready SHALL stay 1.
REQ-036 Decimal 1234: in_ready=0 for 33 edges, the display SHALL change on the 33rd edge to 4, 3, 2, 1, and overflow SHALL be 0.
REQ-037 Decimal -42: digits 3..0 SHALL show '-', 0, 4, 2 without the macro, and blank, '-', 4, 2 with it.
REQ-038 Overflow cases:
- Decimal 10000 SHALL give overflow=1 and all four digits showing 'E'.
- -1000 SHALL give overflow=1.
- -999 SHALL give overflow=0 and digits '-', 9, 9, 9.
- -2147483648 SHALL give overflow=1.
REQ-039 Reset mid-conversion: rst asserted at CONV cycle 10 SHALL give in_ready=1 and all digits 0; a subsequent accept of decimal 7 SHALL show 7 after 33 edges.
